// File: rtl/cacheline_arbiter_pkg.sv
// cacheline_arbiter_pkg: shared FSM state and grant-owner types for the cacheline arbiter
package arbiter_types;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;
endpackage

// File: rtl/cacheline_arbiter_if.sv
// cacheline_arbiter_if: icache/dcache/pmem line buses; slave = arbiter view, master = cache/memory side
interface cacheline_arbiter_if #(parameter int LINE_WIDTH = 256, parameter int ADDR_WIDTH = 32);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cacheline_arbiter_perf_counters.sv
// arbiter_perf_counters: four free-running wrap-around counters (clk, rst, increment enables in; counts out)
module arbiter_perf_counters #(parameter int CNT_WIDTH = 32) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_i,
  input  logic                 inc_d,
  input  logic                 inc_conflict,
  input  logic                 inc_wait,
  output logic [CNT_WIDTH-1:0] cnt_i_grants,
  output logic [CNT_WIDTH-1:0] cnt_d_grants,
  output logic [CNT_WIDTH-1:0] cnt_conflicts,
  output logic [CNT_WIDTH-1:0] cnt_wait_cycles
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_i_grants    <= '0;
      cnt_d_grants    <= '0;
      cnt_conflicts   <= '0;
      cnt_wait_cycles <= '0;
    end else begin
      cnt_i_grants    <= cnt_i_grants + CNT_WIDTH'(inc_i);
      cnt_d_grants    <= cnt_d_grants + CNT_WIDTH'(inc_d);
      cnt_conflicts   <= cnt_conflicts + CNT_WIDTH'(inc_conflict);
      cnt_wait_cycles <= cnt_wait_cycles + CNT_WIDTH'(inc_wait);
    end
endmodule

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: round-robin share of one pmem line port between icache and dcache (clk, rst, bus slave, perf counts)
module cacheline_arbiter import arbiter_types::*; #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cacheline_arbiter_if.slave   bus,
  output logic [CNT_WIDTH-1:0] cnt_i_grants,
  output logic [CNT_WIDTH-1:0] cnt_d_grants,
  output logic [CNT_WIDTH-1:0] cnt_conflicts,
  output logic [CNT_WIDTH-1:0] cnt_wait_cycles
);
  arb_state_t            state, state_nxt;
  grant_t                last_grant;
  logic                  d_pend, inc_i, inc_d, conflict, waiting;
  logic                  rd, wr, i_resp, d_resp;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LINE_WIDTH-1:0] wdata;
  assign d_pend = bus.d_read | bus.d_write;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      state      <= state_nxt;
      last_grant <= inc_i ? GRANT_I : inc_d ? GRANT_D : last_grant;
    end
  // Strobes track the live request inputs so a withdrawn request is visible downstream.
  always_comb begin
    state_nxt = state;
    conflict  = 1'b0;
    inc_i     = 1'b0;
    inc_d     = 1'b0;
    rd        = 1'b0;
    wr        = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    addr      = '0;
    wdata     = '0;
    case (state)
      IDLE: begin
        conflict  = bus.i_read & d_pend;
        state_nxt = conflict ? (last_grant == GRANT_I ? SERVE_D : SERVE_I)
                  : bus.i_read ? SERVE_I : d_pend ? SERVE_D : IDLE;
      end
      SERVE_I: begin
        rd        = bus.i_read;
        addr      = bus.i_address;
        i_resp    = bus.pmem_resp;
        inc_i     = bus.pmem_resp;
        state_nxt = bus.pmem_resp ? RELEASE : SERVE_I;
      end
      SERVE_D: begin
        rd        = bus.d_read & ~bus.d_write;
        wr        = bus.d_write;
        addr      = bus.d_address;
        wdata     = bus.d_wdata;
        d_resp    = bus.pmem_resp;
        inc_d     = bus.pmem_resp;
        state_nxt = bus.pmem_resp ? RELEASE : SERVE_D;
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign waiting          = (bus.i_read & (state != SERVE_I)) | (d_pend & (state != SERVE_D));
  assign bus.pmem_read    = rd;
  assign bus.pmem_write   = wr;
  assign bus.pmem_address = addr;
  assign bus.pmem_wdata   = wdata;
  assign bus.i_resp       = i_resp;
  assign bus.d_resp       = d_resp;
  assign bus.i_rdata      = i_resp ? bus.pmem_rdata : '0;
  assign bus.d_rdata      = d_resp ? bus.pmem_rdata : '0;
  arbiter_perf_counters #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc_i(inc_i),
    .inc_d(inc_d),
    .inc_conflict(conflict),
    .inc_wait(waiting),
    .cnt_i_grants(cnt_i_grants),
    .cnt_d_grants(cnt_d_grants),
    .cnt_conflicts(cnt_conflicts),
    .cnt_wait_cycles(cnt_wait_cycles)
  );
endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: directed self-checking bench for cacheline_arbiter
module tb_cacheline_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cnt_i, cnt_d, cnt_c, cnt_w;
  int          n_assert = 0;
  int          n_fail = 0;
  int          exp_w;
  cacheline_arbiter_if bus();
  cacheline_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .cnt_i_grants(cnt_i),
    .cnt_d_grants(cnt_d),
    .cnt_conflicts(cnt_c),
    .cnt_wait_cycles(cnt_w)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle_inputs();
    bus.i_read     = 1'b0;
    bus.i_address  = '0;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_address  = '0;
    bus.d_wdata    = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    idle_inputs();
    #2;
    chk("rst_pmem_read", bus.pmem_read, 0);
    chk("rst_pmem_write", bus.pmem_write, 0);
    chk("rst_resps", {bus.i_resp, bus.d_resp}, 0);
    chk("rst_addr", bus.pmem_address, 0);
    chk("rst_wdata", bus.pmem_wdata, 0);
    chk("rst_rdata", bus.i_rdata | bus.d_rdata, 0);
    chk("rst_counters", {cnt_i, cnt_d, cnt_c, cnt_w}, 0);
    tick();
    tick();
    rst = 1'b0;
    // single icache read, request held one cycle past resp
    bus.i_read = 1'b1;
    bus.i_address = 32'h0000_0060;
    settle();
    chk("t1_idle_no_strobe", bus.pmem_read, 0);
    tick();
    chk("t1_pmem_read", bus.pmem_read, 1);
    chk("t1_pmem_addr", bus.pmem_address, 32'h60);
    chk("t1_no_early_resp", bus.i_resp, 0);
    repeat (9) tick();
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = 256'hA5;
    settle();
    chk("t1_i_resp", bus.i_resp, 1);
    chk("t1_i_rdata", bus.i_rdata, 256'hA5);
    chk("t1_d_resp", bus.d_resp, 0);
    chk("t1_d_rdata", bus.d_rdata, 0);
    tick();
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata = '0;
    settle();
    chk("t1_release_no_read", bus.pmem_read, 0);
    chk("t1_cnt_i", cnt_i, 1);
    tick();
    bus.i_read = 1'b0;
    settle();
    chk("t1_idle_no_read", bus.pmem_read, 0);
    tick();
    chk("t1_single_grant", bus.pmem_read, 0);
    chk("t1_cnt_i_once", cnt_i, 1);
    chk("t1_cnt_wait", cnt_w, 2);
    chk("t1_cnt_conf", cnt_c, 0);
    // simultaneous requests after reset: D first
    do_reset();
    repeat (3) tick();
    bus.i_read = 1'b1;
    bus.i_address = 32'h200;
    bus.d_read = 1'b1;
    bus.d_address = 32'h100;
    settle();
    chk("t2_idle_no_strobe", bus.pmem_read, 0);
    tick();
    chk("t2_d_first_read", bus.pmem_read, 1);
    chk("t2_d_first_addr", bus.pmem_address, 32'h100);
    chk("t2_no_write", bus.pmem_write, 0);
    chk("t2_cnt_conf", cnt_c, 1);
    tick();
    tick();
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = 256'h77;
    settle();
    chk("t2_d_resp", bus.d_resp, 1);
    chk("t2_d_rdata", bus.d_rdata, 256'h77);
    chk("t2_i_resp_off", bus.i_resp, 0);
    chk("t2_i_rdata_off", bus.i_rdata, 0);
    tick();
    bus.d_read = 1'b0;
    bus.pmem_resp = 1'b0;
    settle();
    chk("t2_release", bus.pmem_read, 0);
    chk("t2_cnt_d", cnt_d, 1);
    tick();
    chk("t2_idle_gap", bus.pmem_read, 0);
    tick();
    chk("t2_i_read", bus.pmem_read, 1);
    chk("t2_i_addr", bus.pmem_address, 32'h200);
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = 256'h88;
    settle();
    chk("t2_i_resp", bus.i_resp, 1);
    chk("t2_i_rdata", bus.i_rdata, 256'h88);
    tick();
    bus.i_read = 1'b0;
    bus.pmem_resp = 1'b0;
    settle();
    chk("t2_cnt_i", cnt_i, 1);
    chk("t2_cnt_conf_final", cnt_c, 1);
    chk("t2_cnt_wait", cnt_w, 6);
    // alternation: both requesters always pending
    do_reset();
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    bus.i_address = 32'h400;
    bus.d_address = 32'h800;
    exp_w = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk($sformatf("t3_grant%0d", t), bus.pmem_address, (t % 2 == 0) ? 32'h800 : 32'h400);
      repeat (t) tick();
      bus.pmem_resp = 1'b1;
      bus.pmem_rdata = 256'(t + 1);
      settle();
      chk($sformatf("t3_resp%0d", t), (t % 2 == 0) ? bus.d_resp : bus.i_resp, 1);
      chk($sformatf("t3_other%0d", t), (t % 2 == 0) ? bus.i_resp : bus.d_resp, 0);
      tick();
      bus.pmem_resp = 1'b0;
      settle();
      chk($sformatf("t3_release%0d", t), bus.pmem_read, 0);
      tick();
      exp_w += 3 + t;
    end
    chk("t3_cnt_conf", cnt_c, 6);
    chk("t3_cnt_wait", cnt_w, exp_w);
    chk("t3_cnt_d", cnt_d, 3);
    chk("t3_cnt_i", cnt_i, 3);
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    // stray pmem_resp in IDLE, then dcache writeback with read+write high
    do_reset();
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = 256'h99;
    settle();
    chk("t4_stray_resp", {bus.i_resp, bus.d_resp}, 0);
    chk("t4_stray_rdata", bus.d_rdata, 0);
    tick();
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata = '0;
    bus.d_read = 1'b1;
    bus.d_write = 1'b1;
    bus.d_address = 32'h0000_1F00;
    bus.d_wdata = 256'hDEAD_BEEF;
    tick();
    chk("t4_write", bus.pmem_write, 1);
    chk("t4_no_read", bus.pmem_read, 0);
    chk("t4_addr", bus.pmem_address, 32'h1F00);
    chk("t4_wdata", bus.pmem_wdata, 256'hDEAD_BEEF);
    tick();
    bus.pmem_resp = 1'b1;
    settle();
    chk("t4_d_resp", bus.d_resp, 1);
    tick();
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.pmem_resp = 1'b0;
    settle();
    chk("t4_cnt_d", cnt_d, 1);
    tick();
    // reset in the middle of a write
    bus.d_write = 1'b1;
    bus.d_address = 32'h2000;
    tick();
    chk("t5_write_active", bus.pmem_write, 1);
    rst = 1'b1;
    settle();
    chk("t5_async_write_off", bus.pmem_write, 0);
    chk("t5_async_counters", {cnt_i, cnt_d, cnt_c, cnt_w}, 0);
    tick();
    bus.d_write = 1'b0;
    rst = 1'b0;
    bus.i_read = 1'b1;
    bus.i_address = 32'h3000;
    tick();
    chk("t5_i_read", bus.pmem_read, 1);
    chk("t5_i_addr", bus.pmem_address, 32'h3000);
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = 256'h55;
    settle();
    chk("t5_i_resp", bus.i_resp, 1);
    tick();
    bus.i_read = 1'b0;
    bus.pmem_resp = 1'b0;
    settle();
    chk("t5_cnt_i", cnt_i, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Shares the single cacheline-wide physical memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two L1 caches and the cacheline adaptor that fronts the burst memory model.
- Grants one requester per transaction; round-robin when both are pending.
- Keeps performance counters that the bench prints at halt, next to the branch-prediction statistics.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits.
- ADDR_WIDTH, 32, byte address width.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_read  in  1  icache line read request; held until i_resp.
- i_address  in  ADDR_WIDTH  icache line address.
- i_rdata  out  LINE_WIDTH  line returned to icache.
- i_resp  out  1  icache transaction complete.
- d_read  in  1  dcache line read request.
- d_write  in  1  dcache line write request.
- d_address  in  ADDR_WIDTH  dcache line address.
- d_wdata  in  LINE_WIDTH  dcache writeback line.
- d_rdata  out  LINE_WIDTH  line returned to dcache.
- d_resp  out  1  dcache transaction complete.
- pmem_read  out  1  downstream read.
- pmem_write  out  1  downstream write.
- pmem_address  out  ADDR_WIDTH  downstream address.
- pmem_wdata  out  LINE_WIDTH  downstream write line.
- pmem_rdata  in  LINE_WIDTH  downstream read line.
- pmem_resp  in  1  downstream complete.
- cnt_i_grants  out  CNT_WIDTH  icache transactions completed.
- cnt_d_grants  out  CNT_WIDTH  dcache transactions completed.
- cnt_conflicts  out  CNT_WIDTH  IDLE cycles with both requesters pending.
- cnt_wait_cycles  out  CNT_WIDTH  cycles any request waits ungranted.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, RELEASE. A state register plus a last_grant register (I or D); everything else is combinational.
- Reset (asynchronous, active-high):
  - state=IDLE, last_grant=I, so D wins the first conflict.
  - All counters 0.
  - pmem_read, pmem_write, i_resp and d_resp are 0.
  - pmem_address and pmem_wdata are 0.
  - i_rdata and d_rdata are 0.
  - Reset mid-transaction abandons the transaction; the downstream port is reset from the same rst.
- IDLE:
  - d_pend = d_read|d_write.
  - Only i_read: go to SERVE_I.
  - Only d_pend: go to SERVE_D.
  - Both: grant the requester other than last_grant, and increment cnt_conflicts.
  - No pmem strobes are driven in IDLE.
- SERVE_I:
  - pmem_read=1, pmem_address=i_address.
  - On pmem_resp: i_resp=1 and i_rdata=pmem_rdata in the same cycle, combinational pass-through.
  - last_grant<=I, cnt_i_grants++, next state RELEASE.
- SERVE_D:
  - pmem_read=d_read, pmem_write=d_write, pmem_address=d_address, pmem_wdata=d_wdata.
  - If d_read and d_write are both high, the write wins and pmem_read=0.
  - On pmem_resp: d_resp=1 and d_rdata=pmem_rdata in the same cycle. last_grant<=D, cnt_d_grants++, next state RELEASE.
- RELEASE: one cycle with no strobes and all requests ignored. This lets the requester drop its request after resp without being regranted. Next state is IDLE.
- pmem_resp outside SERVE_I/SERVE_D is ignored.
- Latency: a request first seen in IDLE at cycle N gives pmem strobes at N+1. A back-to-back second requester is granted no earlier than 2 cycles after the first resp.
- Request withdrawn while SERVE_x is held: the strobes follow the input, which is illegal. The bench flags it; the arbiter stays in SERVE_x until pmem_resp.
- Counters are free-running and wrap modulo 2^CNT_WIDTH with no saturation.
- cnt_wait_cycles increments by 1 per cycle in which at least one requester is pending and not currently granted. This includes IDLE and RELEASE cycles.
- Non-granted requester: resp=0, rdata=0.
- Address and wdata are passed through unregistered; requesters hold them stable until resp.

Decomposition:
- Package arbiter_types: enum arb_state_t {IDLE, SERVE_I, SERVE_D, RELEASE} and enum grant_t {GRANT_I, GRANT_D}.
- One sub-module, arbiter_perf_counters: holds the four counters with increment enables driven from the FSM.

Test Plan:
- Single icache read: after reset, i_read=1, i_address=0x0000_0060, pmem_resp after 10 cycles with pmem_rdata=256'hA5.
  - pmem_read and address appear next cycle.
  - i_resp=1 with i_rdata=256'hA5 in the resp cycle.
  - cnt_i_grants=1.
- Simultaneous after reset: i_read and d_read both asserted in cycle 6.
  - D granted first; I is granted after D's resp plus RELEASE.
  - cnt_conflicts=1, cnt_d_grants=1 then cnt_i_grants=1.
- Alternation: both requesters re-request immediately after every resp for 6 transactions.
  - Grant order D,I,D,I,D,I.
  - cnt_conflicts=6 and cnt_wait_cycles equal the bench-computed total.
- Dcache writeback: d_write=1, d_address=0x0000_1F00, d_wdata=256'hDEAD_BEEF.
  - pmem_write=1 with matching address and data, pmem_read=0.
  - d_resp when pmem_resp; d_read and d_write both high yields a write only.
- Held request after resp: requester keeps i_read high one extra cycle.
  - No second pmem_read during RELEASE.
  - If i_read is still high in IDLE, a new grant is made; the bench checks only one grant occurs when i_read drops on time.
- Reset mid-SERVE_D: assert rst while pmem_write=1.
  - Immediately (asynchronously) pmem_write=0, all counters 0.
  - After release, a new i_read is granted normally.
